// File: rtl/beam_coeff_bank_ctrl_pkg.sv
// Shared defaults, FSM encoding, unity constant and address helpers for beam_coeff_bank_ctrl.
// Build defaults stand in for beamformer_defines.vh when that header has not already set them.
`ifndef NUM_CH_PER_LANE
`define NUM_CH_PER_LANE 4
`endif
`ifndef COEFF_WIDTH
`define COEFF_WIDTH 16
`endif
`ifndef WEIGHT_UPDATE_PERIOD
`define WEIGHT_UPDATE_PERIOD 8
`endif
`ifndef Q15_ONE
`define Q15_ONE 16'h7FFF
`endif

// Split a {beam, ch} write address into its fields.
`define COEFF_ADDR_BEAM(addr, bw, cw) addr[(bw)+(cw)-1 -: (bw)]
`define COEFF_ADDR_CH(addr, cw) addr[(cw)-1:0]

package beam_coeff_bank_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ARMED = 2'd2,
        ST_COPY  = 2'd3
    } state_t;

    localparam logic [15:0] Q15_ONE = `Q15_ONE;

    function automatic int coeff_depth(input int num_beams, input int num_ch);
        return num_beams * num_ch;
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/beam_coeff_bank_ctrl_frame_counter.sv
// Sample position within the weight-update frame; flags the last sample of each frame.
module coeff_frame_counter #(
    parameter int UPDATE_PERIOD = 8
) (
    input  logic        core_clk,
    input  logic        core_rst_n,
    input  logic        run,
    input  logic        sample_valid,
    output logic [31:0] sample_count,
    output logic        boundary
);

    localparam logic [31:0] LAST = 32'(UPDATE_PERIOD - 1);

    assign boundary = run && sample_valid && (sample_count == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            sample_count <= '0;
        end else if (!run || boundary) begin
            sample_count <= '0;
        end else if (sample_valid) begin
            sample_count <= sample_count + 32'd1;
        end
    end

endmodule

// File: rtl/beam_coeff_bank_ctrl.sv
// Multi-beam active/shadow coefficient banks with frame-aligned commit.
// Define COEFF_SHADOW_COPY_EN to copy the new active bank into the shadow bank after each swap.
module beam_coeff_bank_ctrl
    import beam_coeff_bank_ctrl_pkg::*;
#(
    parameter int NUM_BEAMS     = 4,
    parameter int NUM_CH        = `NUM_CH_PER_LANE,
    parameter int COEFF_WIDTH   = `COEFF_WIDTH,
    parameter int UPDATE_PERIOD = `WEIGHT_UPDATE_PERIOD,
    parameter int BEAM_W        = 2,
    parameter int CH_W          = 5
) (
    input  logic                            core_clk,
    input  logic                            core_rst_n,
    input  logic                            sample_valid,
    input  logic [BEAM_W-1:0]               beam_sel,
    output logic [NUM_CH*2*COEFF_WIDTH-1:0] coeff_data,
    output logic                            coeff_valid,
    input  logic                            wr_en,
    input  logic [BEAM_W+CH_W-1:0]          wr_addr,
    input  logic [2*COEFF_WIDTH-1:0]        wr_data,
    output logic                            wr_ready,
    input  logic                            commit_req,
    output logic                            commit_ack,
    output logic                            active_bank,
    output logic                            busy,
    output logic [31:0]                     sample_count,
    output logic [15:0]                     swap_count,
    output logic                            addr_err
);

    localparam int DEPTH = coeff_depth(NUM_BEAMS, NUM_CH);
    localparam int IDX_W = idx_width(DEPTH);
    localparam int EW    = 2 * COEFF_WIDTH;
    localparam logic [EW-1:0]    UNITY    = EW'(Q15_ONE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       idx;
    logic [EW-1:0]          bank [2][DEPTH];
    logic                   boundary;
    logic                   swap;
    logic [BEAM_W-1:0]      wr_beam;
    logic [CH_W-1:0]        wr_ch;
    logic                   wr_in_range;
    logic                   wr_fire;
    logic [IDX_W-1:0]       wr_idx;
    logic                   rd_bank;
    logic                   rd_ok;
    logic [NUM_CH*EW-1:0]   rd_vec;

    coeff_frame_counter #(
        .UPDATE_PERIOD(UPDATE_PERIOD)
    ) u_frame_counter (
        .core_clk    (core_clk),
        .core_rst_n  (core_rst_n),
        .run         (state != ST_INIT),
        .sample_valid(sample_valid),
        .sample_count(sample_count),
        .boundary    (boundary)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        busy       = 1'b0;
        commit_ack = 1'b0;
        case (state)
            ST_INIT: begin
                busy = 1'b1;
                if (idx == LAST_IDX) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                wr_ready = 1'b1;
                if (commit_req) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (boundary) begin
                    commit_ack = 1'b1;
`ifdef COEFF_SHADOW_COPY_EN
                    state_next = ST_COPY;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
`ifdef COEFF_SHADOW_COPY_EN
            ST_COPY: begin
                busy = 1'b1;
                if (idx == LAST_IDX) state_next = ST_IDLE;
            end
`endif
            default: state_next = ST_INIT;
        endcase
    end

    assign swap = commit_ack;

    assign wr_beam     = `COEFF_ADDR_BEAM(wr_addr, BEAM_W, CH_W);
    assign wr_ch       = `COEFF_ADDR_CH(wr_addr, CH_W);
    assign wr_in_range = (int'(wr_beam) < NUM_BEAMS) && (int'(wr_ch) < NUM_CH);
    assign wr_fire     = wr_en && wr_ready && wr_in_range;
    assign wr_idx      = wr_in_range ? IDX_W'(int'(wr_beam) * NUM_CH + int'(wr_ch)) : '0;

    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            state       <= ST_INIT;
            idx         <= '0;
            active_bank <= 1'b0;
            swap_count  <= '0;
            addr_err    <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= (busy && idx != LAST_IDX) ? idx + 1'b1 : '0;
            if (swap) begin
                active_bank <= ~active_bank;
                swap_count  <= swap_count + 16'd1;
            end
            if (wr_en && wr_ready && !wr_in_range) addr_err <= 1'b1;
        end
    end

    // NOTE: the banks carry no reset branch; INIT rewrites every entry after reset, so they stay plain RAM.
    always_ff @(posedge core_clk) begin
        if (core_rst_n) begin
            if (state == ST_INIT) begin
                bank[0][idx] <= UNITY;
                bank[1][idx] <= UNITY;
            end
`ifdef COEFF_SHADOW_COPY_EN
            else if (state == ST_COPY) begin
                bank[~active_bank][idx] <= bank[active_bank][idx];
            end
`endif
            else if (wr_fire) begin
                bank[~active_bank][wr_idx] <= wr_data;
            end
        end
    end

    // Read from the bank that will be active next cycle so data follows a swap immediately.
    assign rd_bank = active_bank ^ swap;
    assign rd_ok   = int'(beam_sel) < NUM_BEAMS;

    always_comb begin
        rd_vec = '0;
        if (rd_ok) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_vec[c*EW +: EW] = bank[rd_bank][IDX_W'(int'(beam_sel) * NUM_CH + c)];
            end
        end
    end

    // The last INIT entry is still being written, so the first valid word is forced to unity.
    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            coeff_data  <= '0;
            coeff_valid <= 1'b0;
        end else if (state == ST_INIT) begin
            coeff_valid <= (idx == LAST_IDX) && rd_ok;
            coeff_data  <= ((idx == LAST_IDX) && rd_ok) ? {NUM_CH{UNITY}} : '0;
        end else begin
            coeff_valid <= rd_ok;
            coeff_data  <= rd_vec;
        end
    end

endmodule

// File: tb/tb_beam_coeff_bank_ctrl.sv
// Scoreboard bench for beam_coeff_bank_ctrl: time-stamped expectations checked by a negedge monitor.
module tb_beam_coeff_bank_ctrl;

    localparam int NB = 2;
    localparam int NC = 4;
    localparam int W  = 16;
    localparam int DW = NC * 2 * W;
    localparam logic [DW-1:0] UNITY_V = {NC{32'h0000_7FFF}};
    localparam logic [DW-1:0] V1      = {32'h0000_7FFF, 32'h1000_2000, 32'h0000_7FFF, 32'h0000_7FFF};

    typedef enum {S_BUSY, S_VALID, S_DATA, S_BANK, S_SWAPS, S_ERR, S_WRRDY, S_SCNT} sig_e;
    typedef struct {
        int            cyc;
        sig_e          sig;
        logic [DW-1:0] val;
    } exp_t;

    logic          core_clk = 1'b0;
    logic          core_rst_n;
    logic          sample_valid;
    logic [1:0]    beam_sel;
    logic [DW-1:0] coeff_data;
    logic          coeff_valid;
    logic          wr_en;
    logic [6:0]    wr_addr;
    logic [31:0]   wr_data;
    logic          wr_ready;
    logic          commit_req;
    logic          commit_ack;
    logic          active_bank;
    logic          busy;
    logic [31:0]   sample_count;
    logic [15:0]   swap_count;
    logic          addr_err;

    exp_t exp_q[$];
    int   ack_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   want_ack;
    int   r0, t0, c2, ack2, e_cyc, ack3, r2, r3, ack4;

    beam_coeff_bank_ctrl #(
        .NUM_BEAMS(NB), .NUM_CH(NC), .COEFF_WIDTH(W), .UPDATE_PERIOD(8), .BEAM_W(2), .CH_W(5)
    ) dut (
        .core_clk    (core_clk),
        .core_rst_n  (core_rst_n),
        .sample_valid(sample_valid),
        .beam_sel    (beam_sel),
        .coeff_data  (coeff_data),
        .coeff_valid (coeff_valid),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .commit_req  (commit_req),
        .commit_ack  (commit_ack),
        .active_bank (active_bank),
        .busy        (busy),
        .sample_count(sample_count),
        .swap_count  (swap_count),
        .addr_err    (addr_err)
    );

    always #5 core_clk = ~core_clk;
    always @(posedge core_clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic exp_at(input int c, input sig_e s, input logic [DW-1:0] v);
        exp_t e;
        int   pos;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        pos = 0;
        while (pos < exp_q.size() && exp_q[pos].cyc <= c) pos++;
        exp_q.insert(pos, e);
    endtask

    task automatic do_write(input int beam, input int ch, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = {2'(beam), 5'(ch)};
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    // Monitor: compares whatever expectations fall due this cycle, and every commit_ack pulse.
    always @(negedge core_clk) begin
        exp_t          e;
        logic [DW-1:0] act;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            case (e.sig)
                S_BUSY:  act = DW'(busy);
                S_VALID: act = DW'(coeff_valid);
                S_DATA:  act = coeff_data;
                S_BANK:  act = DW'(active_bank);
                S_SWAPS: act = DW'(swap_count);
                S_ERR:   act = DW'(addr_err);
                S_WRRDY: act = DW'(wr_ready);
                default: act = DW'(sample_count);
            endcase
            checks++;
            if (e.cyc != cyc || act !== e.val) begin
                errors++;
                $display("FAIL %s at cycle %0d (due %0d): got %h want %h", e.sig.name(), cyc, e.cyc, act, e.val);
            end
        end
        if (commit_ack === 1'b1) begin
            checks++;
            if (ack_q.size() == 0) begin
                errors++;
                $display("FAIL commit_ack: got unexpected pulse at cycle %0d want none", cyc);
            end else begin
                want_ack = ack_q.pop_front();
                if (want_ack != cyc) begin
                    errors++;
                    $display("FAIL commit_ack: got pulse at cycle %0d want cycle %0d", cyc, want_ack);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got no finish by time %0t want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        core_rst_n = 1'b0; sample_valid = 1'b0; beam_sel = 2'd0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit_req = 1'b0;
        repeat (3) tick();

        // Reset state, then INIT for NB*NC = 8 cycles.
        core_rst_n = 1'b1;
        r0 = cyc;
        exp_at(r0, S_BUSY, DW'(1));   exp_at(r0, S_VALID, DW'(0));  exp_at(r0, S_DATA, '0);
        exp_at(r0, S_BANK, DW'(0));   exp_at(r0, S_SWAPS, DW'(0));  exp_at(r0, S_ERR, DW'(0));
        exp_at(r0, S_WRRDY, DW'(0));  exp_at(r0, S_SCNT, DW'(0));
        exp_at(r0 + 7, S_BUSY, DW'(1)); exp_at(r0 + 7, S_VALID, DW'(0));
        exp_at(r0 + 8, S_BUSY, DW'(0)); exp_at(r0 + 8, S_VALID, DW'(1));
        exp_at(r0 + 8, S_DATA, UNITY_V); exp_at(r0 + 8, S_WRRDY, DW'(1));
        wait_until(r0 + 8);

        // Frame starts here: boundaries at t0+7, t0+15, ...
        t0 = cyc;
        sample_valid = 1'b1;
        beam_sel = 2'd1;
        ack_q.push_back(t0 + 7);
        exp_at(t0 + 5, S_WRRDY, DW'(0));
        exp_at(t0 + 7, S_SCNT, DW'(7)); exp_at(t0 + 7, S_DATA, UNITY_V); exp_at(t0 + 7, S_BANK, DW'(0));
        exp_at(t0 + 8, S_BANK, DW'(1)); exp_at(t0 + 8, S_SWAPS, DW'(1)); exp_at(t0 + 8, S_DATA, V1);
`ifdef COEFF_SHADOW_COPY_EN
        exp_at(t0 + 8, S_BUSY, DW'(1)); exp_at(t0 + 15, S_BUSY, DW'(1)); exp_at(t0 + 16, S_BUSY, DW'(0));
`else
        exp_at(t0 + 8, S_BUSY, DW'(0));
`endif
        do_write(1, 2, 32'h1000_2000);
        wait_until(t0 + 3);
        do_commit();
        wait_until(t0 + 5);
        do_write(1, 1, 32'hDEAD_BEEF);

`ifdef COEFF_SHADOW_COPY_EN
        // A request during COPY is dropped; the real one lands on a boundary cycle.
        wait_until(t0 + 12);
        do_commit();
        c2 = t0 + 23;
`else
        c2 = t0 + 15;
`endif
        ack2 = c2 + 8;
        ack_q.push_back(ack2);
        exp_at(ack2 + 1, S_BANK, DW'(0)); exp_at(ack2 + 1, S_SWAPS, DW'(2));
`ifdef COEFF_SHADOW_COPY_EN
        exp_at(ack2 + 1, S_DATA, V1);
        e_cyc = ack2 + 9;
`else
        exp_at(ack2 + 1, S_DATA, UNITY_V);
        e_cyc = ack2 + 1;
`endif
        wait_until(c2);
        do_commit();

        // Out-of-range channel: dropped, addr_err set, then swap it in to prove nothing landed.
        wait_until(e_cyc);
        exp_at(e_cyc, S_ERR, DW'(0));
        exp_at(e_cyc + 1, S_ERR, DW'(1));
        do_write(1, 5, 32'hAAAA_5555);
        ack3 = t0 + 7;
        while (ack3 <= e_cyc + 1) ack3 += 8;
        ack_q.push_back(ack3);
        do_commit();
        exp_at(ack3 + 1, S_DATA, UNITY_V); exp_at(ack3 + 1, S_BANK, DW'(1)); exp_at(ack3 + 1, S_SWAPS, DW'(3));
        exp_at(ack3 + 2, S_DATA, V1);
        exp_at(ack3 + 3, S_VALID, DW'(0)); exp_at(ack3 + 3, S_DATA, '0);
`ifdef COEFF_SHADOW_COPY_EN
        exp_at(ack3 + 4, S_BUSY, DW'(1));
`else
        exp_at(ack3 + 4, S_BUSY, DW'(0));
`endif
        wait_until(ack3);
        beam_sel = 2'd0;
        tick();
        beam_sel = 2'd1;
        tick();
        beam_sel = 2'd3;
        tick();
        beam_sel = 2'd1;
        tick();

        // Reset (mid-COPY when enabled), then a second reset part-way through INIT.
        core_rst_n = 1'b0;
        tick();
        tick();
        core_rst_n = 1'b1;
        r2 = cyc;
        exp_at(r2, S_BUSY, DW'(1)); exp_at(r2, S_SWAPS, DW'(0)); exp_at(r2, S_BANK, DW'(0));
        exp_at(r2, S_VALID, DW'(0)); exp_at(r2, S_SCNT, DW'(0));
        wait_until(r2 + 3);
        core_rst_n = 1'b0;
        tick();
        core_rst_n = 1'b1;
        r3 = cyc;
        exp_at(r3 + 5, S_SCNT, DW'(0));
        exp_at(r3 + 7, S_BUSY, DW'(1));
        exp_at(r3 + 8, S_BUSY, DW'(0)); exp_at(r3 + 8, S_VALID, DW'(1));
        exp_at(r3 + 8, S_DATA, UNITY_V); exp_at(r3 + 8, S_SWAPS, DW'(0));
        exp_at(r3 + 9, S_DATA, UNITY_V);
        // Both banks were reinitialised: swapping to B must show unity where 0x10002000 used to be.
        ack4 = r3 + 15;
        ack_q.push_back(ack4);
        exp_at(ack4 + 1, S_BANK, DW'(1)); exp_at(ack4 + 1, S_SWAPS, DW'(1)); exp_at(ack4 + 1, S_DATA, UNITY_V);
        wait_until(r3 + 9);
        do_commit();
        wait_until(ack4 + 4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: got %0d left want 0", exp_q.size());
        end
        checks++;
        if (ack_q.size() != 0) begin
            errors++;
            $display("FAIL missing_commit_ack: got %0d outstanding want 0", ack_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
